// File: rtl/mem_stage.sv
// mem_stage: consumer end of the EX->MEM pipeline interface.
// Latches an accepted EX instruction, runs its load/store on the data bus
// (lane steering, load extension, bus timeout) and emits a registered
// one-cycle MEM->WB result. Non-memory ops complete in one cycle.
// Optional feature: define MEM_ALIGN_CHECK_EN to trap misaligned
// halfword/word accesses (wb_ale) instead of forcing the aligned lane.
module mem_stage #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int INST_WIDTH   = 32,
    parameter int REG_WIDTH    = 5,
    parameter int LSU_OP_WIDTH = 4,
    parameter int BUS_TIMEOUT  = 255
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    ex_valid,
    output logic                    ex_ready,
    input  logic [INST_WIDTH-1:0]   ex_inst,
    input  logic [ADDR_WIDTH-1:0]   ex_pc,
    input  logic [DATA_WIDTH-1:0]   ex_result,
    input  logic                    ex_rd_wr_en,
    input  logic [REG_WIDTH-1:0]    ex_rd_wr_addr,
    input  logic [DATA_WIDTH-1:0]   ex_lsu_data,
    input  logic [LSU_OP_WIDTH-1:0] ex_lsu_op,
    output logic                    data_req,
    output logic                    data_we,
    output logic [ADDR_WIDTH-1:0]   data_addr,
    output logic [3:0]              data_wstrb,
    output logic [DATA_WIDTH-1:0]   data_wdata,
    input  logic                    data_ack,
    input  logic [DATA_WIDTH-1:0]   data_rdata,
    output logic                    wb_valid,
    output logic [INST_WIDTH-1:0]   wb_inst,
    output logic [ADDR_WIDTH-1:0]   wb_pc,
    output logic                    wb_rd_wr_en,
    output logic [REG_WIDTH-1:0]    wb_rd_wr_addr,
    output logic [DATA_WIDTH-1:0]   wb_result,
    output logic                    wb_bus_err,
    output logic                    wb_ale
);

    localparam int CNT_W   = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT + 1) : 1;
    localparam int TO_LAST = (BUS_TIMEOUT > 0) ? BUS_TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] TO_LAST_C = CNT_W'(TO_LAST);
    localparam logic TO_EN = (BUS_TIMEOUT > 0);

    localparam logic [LSU_OP_WIDTH-1:0] OP_LD_B  = LSU_OP_WIDTH'(1);
    localparam logic [LSU_OP_WIDTH-1:0] OP_LD_H  = LSU_OP_WIDTH'(2);
    localparam logic [LSU_OP_WIDTH-1:0] OP_LD_W  = LSU_OP_WIDTH'(3);
    localparam logic [LSU_OP_WIDTH-1:0] OP_LD_BU = LSU_OP_WIDTH'(4);
    localparam logic [LSU_OP_WIDTH-1:0] OP_LD_HU = LSU_OP_WIDTH'(5);
    localparam logic [LSU_OP_WIDTH-1:0] OP_ST_B  = LSU_OP_WIDTH'(8);
    localparam logic [LSU_OP_WIDTH-1:0] OP_ST_H  = LSU_OP_WIDTH'(9);
    localparam logic [LSU_OP_WIDTH-1:0] OP_ST_W  = LSU_OP_WIDTH'(10);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_REQ = 1'b1} state_t;

    function automatic logic op_is_load(input logic [LSU_OP_WIDTH-1:0] op);
        logic r;
        case (op)
            OP_LD_B, OP_LD_H, OP_LD_W, OP_LD_BU, OP_LD_HU: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic op_is_store(input logic [LSU_OP_WIDTH-1:0] op);
        logic r;
        case (op)
            OP_ST_B, OP_ST_H, OP_ST_W: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Byte enables; the halfword lane is chosen by a[1] only, so a[0] is ignored.
    function automatic logic [3:0] store_strb(input logic [LSU_OP_WIDTH-1:0] op,
                                              input logic [1:0] a);
        logic [3:0] r;
        case (op)
            OP_ST_B: r = 4'b0001 << a;
            OP_ST_H: r = 4'b0011 << {a[1], 1'b0};
            OP_ST_W: r = 4'b1111;
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] store_data(input logic [LSU_OP_WIDTH-1:0] op,
                                                         input logic [DATA_WIDTH-1:0] d);
        logic [DATA_WIDTH-1:0] r;
        case (op)
            OP_ST_B: r = {4{d[7:0]}};
            OP_ST_H: r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] load_data(input logic [LSU_OP_WIDTH-1:0] op,
                                                        input logic [1:0] a,
                                                        input logic [DATA_WIDTH-1:0] rd);
        logic [7:0]            b;
        logic [15:0]           h;
        logic [DATA_WIDTH-1:0] r;
        b = rd[{a, 3'b000} +: 8];
        h = rd[{a[1], 4'b0000} +: 16];
        case (op)
            OP_LD_B:  r = {{(DATA_WIDTH - 8){b[7]}}, b};
            OP_LD_BU: r = {{(DATA_WIDTH - 8){1'b0}}, b};
            OP_LD_H:  r = {{(DATA_WIDTH - 16){h[15]}}, h};
            OP_LD_HU: r = {{(DATA_WIDTH - 16){1'b0}}, h};
            default:  r = rd;
        endcase
        return r;
    endfunction

`ifdef MEM_ALIGN_CHECK_EN
    function automatic logic op_misaligned(input logic [LSU_OP_WIDTH-1:0] op,
                                           input logic [1:0] a);
        logic r;
        case (op)
            OP_LD_H, OP_LD_HU, OP_ST_H: r = a[0];
            OP_LD_W, OP_ST_W:           r = |a;
            default:                    r = 1'b0;
        endcase
        return r;
    endfunction
`endif

    state_t                  state_r, state_s;
    logic                    ex_ready_r, ex_ready_s;
    logic [LSU_OP_WIDTH-1:0] op_r, op_s;
    logic [INST_WIDTH-1:0]   inst_r, inst_s;
    logic [ADDR_WIDTH-1:0]   pc_r, pc_s;
    logic [DATA_WIDTH-1:0]   res_r, res_s;
    logic                    rd_en_r, rd_en_s;
    logic [REG_WIDTH-1:0]    rd_addr_r, rd_addr_s;
    logic [CNT_W-1:0]        cnt_r, cnt_s;
    logic                    data_req_r, data_req_s;
    logic                    data_we_r, data_we_s;
    logic [ADDR_WIDTH-1:0]   data_addr_r, data_addr_s;
    logic [3:0]              data_wstrb_r, data_wstrb_s;
    logic [DATA_WIDTH-1:0]   data_wdata_r, data_wdata_s;
    logic                    wb_valid_r, wb_valid_s;
    logic [INST_WIDTH-1:0]   wb_inst_r, wb_inst_s;
    logic [ADDR_WIDTH-1:0]   wb_pc_r, wb_pc_s;
    logic                    wb_rd_wr_en_r, wb_rd_wr_en_s;
    logic [REG_WIDTH-1:0]    wb_rd_wr_addr_r, wb_rd_wr_addr_s;
    logic [DATA_WIDTH-1:0]   wb_result_r, wb_result_s;
    logic                    wb_bus_err_r, wb_bus_err_s;
    logic                    wb_ale_r, wb_ale_s;
    logic                    misalign_s;
    logic                    is_mem_s;

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign_s = op_misaligned(ex_lsu_op, ex_result[1:0]);
`else
    assign misalign_s = 1'b0;
`endif
    assign is_mem_s = op_is_load(ex_lsu_op) | op_is_store(ex_lsu_op);

    // Next-state logic: accept in IDLE, then wait for ack or timeout in REQ.
    always_comb begin
        state_s         = state_r;
        ex_ready_s      = ex_ready_r;
        op_s            = op_r;
        inst_s          = inst_r;
        pc_s            = pc_r;
        res_s           = res_r;
        rd_en_s         = rd_en_r;
        rd_addr_s       = rd_addr_r;
        cnt_s           = cnt_r;
        data_req_s      = data_req_r;
        data_we_s       = data_we_r;
        data_addr_s     = data_addr_r;
        data_wstrb_s    = data_wstrb_r;
        data_wdata_s    = data_wdata_r;
        wb_valid_s      = 1'b0;
        wb_inst_s       = wb_inst_r;
        wb_pc_s         = wb_pc_r;
        wb_rd_wr_en_s   = wb_rd_wr_en_r;
        wb_rd_wr_addr_s = wb_rd_wr_addr_r;
        wb_result_s     = wb_result_r;
        wb_bus_err_s    = 1'b0;
        wb_ale_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (ex_valid) begin
                    op_s      = ex_lsu_op;
                    inst_s    = ex_inst;
                    pc_s      = ex_pc;
                    res_s     = ex_result;
                    rd_en_s   = ex_rd_wr_en;
                    rd_addr_s = ex_rd_wr_addr;
                    if (is_mem_s && !misalign_s) begin
                        state_s      = ST_REQ;
                        ex_ready_s   = 1'b0;
                        cnt_s        = {CNT_W{1'b0}};
                        data_req_s   = 1'b1;
                        data_we_s    = op_is_store(ex_lsu_op);
                        data_addr_s  = {ex_result[ADDR_WIDTH-1:2], 2'b00};
                        data_wstrb_s = store_strb(ex_lsu_op, ex_result[1:0]);
                        data_wdata_s = store_data(ex_lsu_op, ex_lsu_data);
                    end else begin
                        // NONE (or trapped misaligned) op: retire next cycle.
                        wb_valid_s      = 1'b1;
                        wb_inst_s       = ex_inst;
                        wb_pc_s         = ex_pc;
                        wb_rd_wr_en_s   = ex_rd_wr_en & ~misalign_s;
                        wb_rd_wr_addr_s = ex_rd_wr_addr;
                        wb_result_s     = ex_result;
                        wb_ale_s        = misalign_s;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (data_ack) begin
                    state_s         = ST_IDLE;
                    ex_ready_s      = 1'b1;
                    data_req_s      = 1'b0;
                    wb_valid_s      = 1'b1;
                    wb_inst_s       = inst_r;
                    wb_pc_s         = pc_r;
                    wb_rd_wr_addr_s = rd_addr_r;
                    if (op_is_store(op_r)) begin
                        wb_rd_wr_en_s = 1'b0;
                        wb_result_s   = res_r;
                    end else begin
                        wb_rd_wr_en_s = rd_en_r;
                        wb_result_s   = load_data(op_r, res_r[1:0], data_rdata);
                    end
                end else if (TO_EN && (cnt_r == TO_LAST_C)) begin
                    // Last allowed cycle without ack: abort the access.
                    state_s         = ST_IDLE;
                    ex_ready_s      = 1'b1;
                    data_req_s      = 1'b0;
                    wb_valid_s      = 1'b1;
                    wb_bus_err_s    = 1'b1;
                    wb_inst_s       = inst_r;
                    wb_pc_s         = pc_r;
                    wb_rd_wr_en_s   = 1'b0;
                    wb_rd_wr_addr_s = rd_addr_r;
                    wb_result_s     = res_r;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_s    = ST_IDLE;
                ex_ready_s = 1'b1;
                data_req_s = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            ex_ready_r      <= 1'b1;
            op_r            <= {LSU_OP_WIDTH{1'b0}};
            inst_r          <= {INST_WIDTH{1'b0}};
            pc_r            <= {ADDR_WIDTH{1'b0}};
            res_r           <= {DATA_WIDTH{1'b0}};
            rd_en_r         <= 1'b0;
            rd_addr_r       <= {REG_WIDTH{1'b0}};
            cnt_r           <= {CNT_W{1'b0}};
            data_req_r      <= 1'b0;
            data_we_r       <= 1'b0;
            data_addr_r     <= {ADDR_WIDTH{1'b0}};
            data_wstrb_r    <= 4'b0000;
            data_wdata_r    <= {DATA_WIDTH{1'b0}};
            wb_valid_r      <= 1'b0;
            wb_inst_r       <= {INST_WIDTH{1'b0}};
            wb_pc_r         <= {ADDR_WIDTH{1'b0}};
            wb_rd_wr_en_r   <= 1'b0;
            wb_rd_wr_addr_r <= {REG_WIDTH{1'b0}};
            wb_result_r     <= {DATA_WIDTH{1'b0}};
            wb_bus_err_r    <= 1'b0;
            wb_ale_r        <= 1'b0;
        end else begin
            state_r         <= state_s;
            ex_ready_r      <= ex_ready_s;
            op_r            <= op_s;
            inst_r          <= inst_s;
            pc_r            <= pc_s;
            res_r           <= res_s;
            rd_en_r         <= rd_en_s;
            rd_addr_r       <= rd_addr_s;
            cnt_r           <= cnt_s;
            data_req_r      <= data_req_s;
            data_we_r       <= data_we_s;
            data_addr_r     <= data_addr_s;
            data_wstrb_r    <= data_wstrb_s;
            data_wdata_r    <= data_wdata_s;
            wb_valid_r      <= wb_valid_s;
            wb_inst_r       <= wb_inst_s;
            wb_pc_r         <= wb_pc_s;
            wb_rd_wr_en_r   <= wb_rd_wr_en_s;
            wb_rd_wr_addr_r <= wb_rd_wr_addr_s;
            wb_result_r     <= wb_result_s;
            wb_bus_err_r    <= wb_bus_err_s;
            wb_ale_r        <= wb_ale_s;
        end
    end

    assign ex_ready      = ex_ready_r;
    assign data_req      = data_req_r;
    assign data_we       = data_we_r;
    assign data_addr     = data_addr_r;
    assign data_wstrb    = data_wstrb_r;
    assign data_wdata    = data_wdata_r;
    assign wb_valid      = wb_valid_r;
    assign wb_inst       = wb_inst_r;
    assign wb_pc         = wb_pc_r;
    assign wb_rd_wr_en   = wb_rd_wr_en_r;
    assign wb_rd_wr_addr = wb_rd_wr_addr_r;
    assign wb_result     = wb_result_r;
    assign wb_bus_err    = wb_bus_err_r;
    assign wb_ale        = wb_ale_r;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized + directed bench for mem_stage, checked every
// cycle against a transaction-level reference model of the MEM stage.
`timescale 1ns/1ps
module tb_mem_stage;

    localparam int TO = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_inst;
    logic [31:0] ex_pc;
    logic [31:0] ex_result;
    logic        ex_rd_wr_en;
    logic [4:0]  ex_rd_wr_addr;
    logic [31:0] ex_lsu_data;
    logic [3:0]  ex_lsu_op;
    logic        data_req;
    logic        data_we;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_ack;
    logic [31:0] data_rdata;
    logic        wb_valid;
    logic [31:0] wb_inst;
    logic [31:0] wb_pc;
    logic        wb_rd_wr_en;
    logic [4:0]  wb_rd_wr_addr;
    logic [31:0] wb_result;
    logic        wb_bus_err;
    logic        wb_ale;

    always #5 clock = ~clock;

    mem_stage #(.BUS_TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_inst(ex_inst), .ex_pc(ex_pc), .ex_result(ex_result),
        .ex_rd_wr_en(ex_rd_wr_en), .ex_rd_wr_addr(ex_rd_wr_addr),
        .ex_lsu_data(ex_lsu_data), .ex_lsu_op(ex_lsu_op),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_ack(data_ack), .data_rdata(data_rdata),
        .wb_valid(wb_valid), .wb_inst(wb_inst), .wb_pc(wb_pc),
        .wb_rd_wr_en(wb_rd_wr_en), .wb_rd_wr_addr(wb_rd_wr_addr),
        .wb_result(wb_result), .wb_bus_err(wb_bus_err), .wb_ale(wb_ale)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // 0 = no memory access, 1 = load, 2 = store
    function automatic int op_kind(input int op);
        if (op inside {1, 2, 3, 4, 5}) return 1;
        if (op inside {8, 9, 10}) return 2;
        return 0;
    endfunction

    function automatic int access_bytes(input int op);
        if (op inside {1, 4, 8}) return 1;
        if (op inside {2, 5, 9}) return 2;
        return 4;
    endfunction

    // Offset of the naturally aligned lane holding the access.
    function automatic logic [31:0] lane_off(input int op, input logic [31:0] addr);
        return ((addr % 32'd4) / access_bytes(op)) * access_bytes(op);
    endfunction

    function automatic logic [31:0] m_load(input int op, input logic [31:0] addr,
                                           input logic [31:0] rdata);
        logic [31:0] span, v;
        if (access_bytes(op) == 4) return rdata;
        span = 32'd1 << (8 * access_bytes(op));
        v = (rdata >> (8 * lane_off(op, addr))) % span;
        if ((op == 1 || op == 2) && v >= (span >> 1)) v = v - span;
        return v;
    endfunction

    function automatic logic [31:0] m_wdata(input int op, input logic [31:0] d);
        if (access_bytes(op) == 1) return (d % 32'd256) * 32'h0101_0101;
        if (access_bytes(op) == 2) return (d % 32'd65536) * 32'h0001_0001;
        return d;
    endfunction

    logic        m_started = 1'b0;
    logic        m_busy;
    int          m_cycles;
    int          t_op;
    logic [31:0] t_addr, t_inst, t_pc;
    logic        t_en;
    logic [4:0]  t_rd;

    logic        exp_ready, exp_req, exp_we;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_wstrb;
    logic        exp_wb_valid, exp_en, exp_err, exp_ale, exp_chk_result;
    logic [31:0] exp_inst, exp_pc, exp_result;
    logic [4:0]  exp_rd;

    task automatic emit(input logic [31:0] inst, input logic [31:0] pc, input logic en,
                        input logic [4:0] rd, input logic [31:0] res, input logic chk_res,
                        input logic err, input logic ale);
        exp_wb_valid   = 1'b1;
        exp_inst       = inst;
        exp_pc         = pc;
        exp_en         = en;
        exp_rd         = rd;
        exp_result     = res;
        exp_chk_result = chk_res;
        exp_err        = err;
        exp_ale        = ale;
    endtask

    // Advance the model by one clock edge using the inputs sampled at that edge.
    task automatic model_edge();
        int   k;
        logic mis;
        exp_wb_valid = 1'b0;
        if (reset) begin
            m_started = 1'b1;
            m_busy    = 1'b0;
            exp_req   = 1'b0;
        end else if (!m_started) begin
            m_busy = 1'b0;
        end else if (!m_busy) begin
            if (ex_valid) begin
                k   = op_kind(int'(ex_lsu_op));
                mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
                if (k != 0) mis = (ex_result % access_bytes(int'(ex_lsu_op))) != 0;
`endif
                if (k != 0 && !mis) begin
                    m_busy    = 1'b1;
                    m_cycles  = 0;
                    t_op      = int'(ex_lsu_op);
                    t_addr    = ex_result;
                    t_inst    = ex_inst;
                    t_pc      = ex_pc;
                    t_en      = ex_rd_wr_en;
                    t_rd      = ex_rd_wr_addr;
                    exp_req   = 1'b1;
                    exp_we    = (k == 2);
                    exp_addr  = ex_result - (ex_result % 32'd4);
                    exp_wstrb = 4'(((32'd1 << access_bytes(t_op)) - 32'd1) << lane_off(t_op, ex_result));
                    exp_wdata = m_wdata(t_op, ex_lsu_data);
                end else begin
                    emit(ex_inst, ex_pc, ex_rd_wr_en && !mis, ex_rd_wr_addr, ex_result,
                         1'b1, 1'b0, mis);
                end
            end
        end else begin
            m_cycles++;
            if (data_ack) begin
                m_busy  = 1'b0;
                exp_req = 1'b0;
                if (op_kind(t_op) == 1)
                    emit(t_inst, t_pc, t_en, t_rd, m_load(t_op, t_addr, data_rdata),
                         1'b1, 1'b0, 1'b0);
                else
                    emit(t_inst, t_pc, 1'b0, t_rd, 32'd0, 1'b0, 1'b0, 1'b0);
            end else if (TO != 0 && m_cycles == TO) begin
                m_busy  = 1'b0;
                exp_req = 1'b0;
                emit(t_inst, t_pc, 1'b0, t_rd, 32'd0, 1'b0, 1'b1, 1'b0);
            end
        end
        exp_ready = !m_busy;
    endtask

    // ---------------- compare process ----------------
    always @(negedge clock) begin
        if (m_started) begin
            chk("ex_ready", 32'(ex_ready), 32'(exp_ready));
            chk("data_req", 32'(data_req), 32'(exp_req));
            if (exp_req) begin
                chk("data_addr", data_addr, exp_addr);
                chk("data_we", 32'(data_we), 32'(exp_we));
                if (exp_we) begin
                    chk("data_wstrb", 32'(data_wstrb), 32'(exp_wstrb));
                    chk("data_wdata", data_wdata, exp_wdata);
                end
            end
            chk("wb_valid", 32'(wb_valid), 32'(exp_wb_valid));
            if (exp_wb_valid) begin
                chk("wb_inst", wb_inst, exp_inst);
                chk("wb_pc", wb_pc, exp_pc);
                chk("wb_rd_wr_en", 32'(wb_rd_wr_en), 32'(exp_en));
                chk("wb_rd_wr_addr", 32'(wb_rd_wr_addr), 32'(exp_rd));
                chk("wb_bus_err", 32'(wb_bus_err), 32'(exp_err));
                chk("wb_ale", 32'(wb_ale), 32'(exp_ale));
                if (exp_chk_result) chk("wb_result", wb_result, exp_result);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clock);
        #1;
        model_edge();
    endtask

    int          r_req;
    logic        r_saw, r_err, r_en, r_ale, r_ready_low;
    logic [31:0] r_res, r_addr, r_wdata;
    logic [3:0]  r_wstrb;

    // One access; ack is raised on REQ cycle ack_after (negative = never).
    task automatic run_access(input logic [3:0] op, input logic [31:0] addr,
                              input logic [31:0] wdat, input int ack_after,
                              input logic [31:0] rdat, input int ncyc);
        r_req = 0; r_saw = 1'b0; r_ready_low = 1'b1;
        ex_valid = 1'b1; ex_lsu_op = op; ex_result = addr; ex_lsu_data = wdat;
        ex_inst = 32'h0000_0013 + addr; ex_pc = 32'h1000 + addr;
        ex_rd_wr_en = 1'b1; ex_rd_wr_addr = 5'd9;
        step();
        ex_valid = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clock);
            if (data_req) begin
                r_req++;
                r_addr = data_addr; r_wstrb = data_wstrb; r_wdata = data_wdata;
                if (ex_ready) r_ready_low = 1'b0;
            end
            if (wb_valid) begin
                r_saw = 1'b1; r_res = wb_result; r_err = wb_bus_err;
                r_en = wb_rd_wr_en; r_ale = wb_ale;
            end
            data_ack = (i == ack_after);
            data_rdata = rdat;
            step();
            data_ack = 1'b0;
        end
    endtask

    int ops[14] = '{0, 1, 2, 3, 4, 5, 8, 9, 10, 6, 7, 11, 12, 15};
    int ack_pct;

    initial begin
        reset = 1'b1; ex_valid = 1'b0; ex_inst = 32'd0; ex_pc = 32'd0; ex_result = 32'd0;
        ex_rd_wr_en = 1'b0; ex_rd_wr_addr = 5'd0; ex_lsu_data = 32'd0; ex_lsu_op = 4'd0;
        data_ack = 1'b0; data_rdata = 32'd0;
        step();
        step();
        reset = 1'b0;
        @(negedge clock);
        chk("rst ex_ready", 32'(ex_ready), 32'd1);
        chk("rst data_req", 32'(data_req), 32'd0);
        chk("rst data_addr", data_addr, 32'd0);
        chk("rst wb_valid", 32'(wb_valid), 32'd0);
        chk("rst wb_result", wb_result, 32'd0);
        chk("rst wb_rd_wr_en", 32'(wb_rd_wr_en), 32'd0);

        // NONE op
        ex_valid = 1'b1; ex_lsu_op = 4'd0; ex_result = 32'h1234_5678;
        ex_rd_wr_addr = 5'd5; ex_rd_wr_en = 1'b1; ex_inst = 32'hABCD_0001; ex_pc = 32'h40;
        step();
        ex_valid = 1'b0;
        @(negedge clock);
        chk("none wb_valid", 32'(wb_valid), 32'd1);
        chk("none wb_result", wb_result, 32'h1234_5678);
        chk("none wb_rd_wr_addr", 32'(wb_rd_wr_addr), 32'd5);
        chk("none data_req", 32'(data_req), 32'd0);

        // LD_B / LD_BU from byte lane 3
        run_access(4'd1, 32'h103, 32'd0, 0, 32'h80FF_0000, 3);
        chk("ldb req cycles", 32'(r_req), 32'd1);
        chk("ldb data_addr", r_addr, 32'h100);
        chk("ldb wb seen", 32'(r_saw), 32'd1);
        chk("ldb wb_result", r_res, 32'hFFFF_FF80);
        run_access(4'd4, 32'h103, 32'd0, 0, 32'h80FF_0000, 3);
        chk("ldbu wb_result", r_res, 32'h0000_0080);

        // ST_H with ack after 3 wait cycles
        run_access(4'd9, 32'h202, 32'hAAAA_BEEF, 3, 32'd0, 6);
        chk("sth req cycles", 32'(r_req), 32'd4);
        chk("sth wstrb", 32'(r_wstrb), 32'hC);
        chk("sth wdata", r_wdata, 32'hBEEF_BEEF);
        chk("sth ready low", 32'(r_ready_low), 32'd1);
        chk("sth wb_rd_wr_en", 32'(r_en), 32'd0);

        // LD_W timeout
        run_access(4'd3, 32'h400, 32'd0, -1, 32'd0, 7);
        chk("to req cycles", 32'(r_req), 32'd4);
        chk("to wb seen", 32'(r_saw), 32'd1);
        chk("to bus_err", 32'(r_err), 32'd1);
        chk("to ex_ready", 32'(ex_ready), 32'd1);

        // Reset during REQ, then ack (late, in IDLE)
        ex_valid = 1'b1; ex_lsu_op = 4'd3; ex_result = 32'h500;
        step();
        ex_valid = 1'b0;
        @(negedge clock);
        chk("rmid data_req", 32'(data_req), 32'd1);
        reset = 1'b1; data_ack = 1'b1; data_rdata = 32'h5555_AAAA;
        step();
        reset = 1'b0;
        @(negedge clock);
        chk("rmid req dropped", 32'(data_req), 32'd0);
        chk("rmid wb_valid", 32'(wb_valid), 32'd0);
        step();
        data_ack = 1'b0;
        @(negedge clock);
        chk("late ack wb_valid", 32'(wb_valid), 32'd0);
        run_access(4'd0, 32'h77, 32'd0, -1, 32'd0, 2);
        chk("post-reset none", r_res, 32'h77);

        // Misaligned word load
        run_access(4'd3, 32'h302, 32'd0, 0, 32'hCAFE_F00D, 3);
`ifdef MEM_ALIGN_CHECK_EN
        chk("ale req cycles", 32'(r_req), 32'd0);
        chk("ale wb_ale", 32'(r_ale), 32'd1);
        chk("ale wb_rd_wr_en", 32'(r_en), 32'd0);
`else
        chk("mis data_addr", r_addr, 32'h300);
        chk("mis wb_result", r_res, 32'hCAFE_F00D);
        chk("mis wb_ale", 32'(r_ale), 32'd0);
`endif

        // Randomized traffic, including invalid op codes and occasional resets
        ack_pct = 50;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc % 200 == 0) ack_pct = ($urandom_range(0, 1) == 1) ? 60 : 8;
            reset         = ($urandom_range(0, 199) == 0);
            ex_valid      = ($urandom_range(0, 99) < 70);
            ex_lsu_op     = 4'(ops[$urandom_range(0, 13)]);
            ex_result     = $urandom;
            ex_inst       = $urandom;
            ex_pc         = $urandom;
            ex_rd_wr_en   = 1'($urandom_range(0, 1));
            ex_rd_wr_addr = 5'($urandom_range(0, 31));
            ex_lsu_data   = $urandom;
            data_ack      = ($urandom_range(0, 99) < ack_pct);
            data_rdata    = $urandom;
            step();
        end
        reset = 1'b0; ex_valid = 1'b0; data_ack = 1'b0;
        step();
        @(negedge clock);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
